// File: rtl/fpu_round_arbiter_if.sv
// -----------------------------------------------------------------------------
// fpu_round_arbiter_if
// Bundles every bus signal of fpu_round_arbiter: the two requester handshakes
// (A = add/sub normalize, B = multiply normalize), the shared rounding-unit
// port, the registered result handshake and the grant counters.
//   slave  : the arbiter's view (drives o_*, reads i_*)
//   master : the surrounding datapath's view (drives i_*, reads o_*)
// Mantissa layout on i_x_mant / o_rnd_mant:
//   [27] carry, [26] hidden, [26:4] kept, [3] G, [2] R, [1:0] S.
// -----------------------------------------------------------------------------
interface fpu_round_arbiter_if #(
  parameter int CNT_W = 16
);
  // Requester A
  logic             i_a_valid;
  logic             o_a_ready;
  logic [7:0]       i_a_exp;
  logic [27:0]      i_a_mant;
  logic             i_a_ov_fl;
  logic             i_a_un_fl;
  // Requester B
  logic             i_b_valid;
  logic             o_b_ready;
  logic [7:0]       i_b_exp;
  logic [27:0]      i_b_mant;
  logic             i_b_ov_fl;
  logic             i_b_un_fl;
  // Shared rounding unit (combinational round trip)
  logic [7:0]       o_rnd_exp;
  logic [27:0]      o_rnd_mant;
  logic             o_rnd_ov_fl;
  logic             o_rnd_un_fl;
  logic [7:0]       i_rnd_exp;
  logic [22:0]      i_rnd_mant;
  logic             i_rnd_ov_fl;
  logic             i_rnd_un_fl;
  // Registered result towards the pack stage
  logic             o_valid;
  logic             i_ready;
  logic [7:0]       o_exp;
  logic [22:0]      o_mant;
  logic             o_ov_fl;
  logic             o_un_fl;
  logic             o_src;
  // Grant statistics
  logic [CNT_W-1:0] o_a_cnt;
  logic [CNT_W-1:0] o_b_cnt;

  modport slave (
    input  i_a_valid, i_a_exp, i_a_mant, i_a_ov_fl, i_a_un_fl,
    input  i_b_valid, i_b_exp, i_b_mant, i_b_ov_fl, i_b_un_fl,
    input  i_rnd_exp, i_rnd_mant, i_rnd_ov_fl, i_rnd_un_fl,
    input  i_ready,
    output o_a_ready, o_b_ready,
    output o_rnd_exp, o_rnd_mant, o_rnd_ov_fl, o_rnd_un_fl,
    output o_valid, o_exp, o_mant, o_ov_fl, o_un_fl, o_src,
    output o_a_cnt, o_b_cnt
  );

  modport master (
    output i_a_valid, i_a_exp, i_a_mant, i_a_ov_fl, i_a_un_fl,
    output i_b_valid, i_b_exp, i_b_mant, i_b_ov_fl, i_b_un_fl,
    output i_rnd_exp, i_rnd_mant, i_rnd_ov_fl, i_rnd_un_fl,
    output i_ready,
    input  o_a_ready, o_b_ready,
    input  o_rnd_exp, o_rnd_mant, o_rnd_ov_fl, o_rnd_un_fl,
    input  o_valid, o_exp, o_mant, o_ov_fl, o_un_fl, o_src,
    input  o_a_cnt, o_b_cnt
  );
endinterface

// File: rtl/fpu_round_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_round_arbiter
// Round-robin arbiter sharing one combinational rounding unit between two FPU
// normalize stages. A granted operand is sent through the rounding unit in
// the same cycle and the rounded result is captured into a single output
// register together with its source ID.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      fpu_round_arbiter_if.slave (requesters, rounding port, result,
//            grant counters)
// Parameters:
//   PRIO_INIT  requester holding priority after reset (0 = A, 1 = B)
//   CNT_W      width of the saturating grant counters
// -----------------------------------------------------------------------------
module fpu_round_arbiter #(
  parameter bit PRIO_INIT = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  fpu_round_arbiter_if.slave  bus
);

  typedef struct packed {
    logic [7:0]  exp;
    logic [22:0] mant;
    logic        ov_fl;
    logic        un_fl;
    logic        src;
  } result_t;

  result_t          res_q;
  logic             valid_q;
  logic             prio_b;     // 1: B wins the next contention
  logic [CNT_W-1:0] a_cnt;
  logic [CNT_W-1:0] b_cnt;

  logic slot_free;
  logic grant_a;
  logic grant_b;
  logic grant;

  // The slot is free when empty or being drained this cycle, which lets a
  // new grant overlap the drain for full throughput. Grants are also masked
  // by reset so readies drop the instant reset is asserted.
  always_comb begin
    slot_free = ~valid_q | bus.i_ready;
    grant_a   = i_rst_n & slot_free & bus.i_a_valid & (~bus.i_b_valid | ~prio_b);
    grant_b   = i_rst_n & slot_free & bus.i_b_valid & (~bus.i_a_valid |  prio_b);
    grant     = grant_a | grant_b;
  end

  assign bus.o_a_ready = grant_a;
  assign bus.o_b_ready = grant_b;

  // Rounding-unit operand mux; driven to zero when idle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    bus.o_rnd_exp   = '0;
    bus.o_rnd_mant  = '0;
    bus.o_rnd_ov_fl = 1'b0;
    bus.o_rnd_un_fl = 1'b0;
    if (grant_a) begin
      bus.o_rnd_exp   = bus.i_a_exp;
      bus.o_rnd_mant  = bus.i_a_mant;
      bus.o_rnd_ov_fl = bus.i_a_ov_fl;
      bus.o_rnd_un_fl = bus.i_a_un_fl;
    end else if (grant_b) begin
      bus.o_rnd_exp   = bus.i_b_exp;
      bus.o_rnd_mant  = bus.i_b_mant;
      bus.o_rnd_ov_fl = bus.i_b_ov_fl;
      bus.o_rnd_un_fl = bus.i_b_un_fl;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: non-blocking everywhere in clocked logic so all registers
      // update from the same pre-edge values.
      valid_q <= 1'b0;
      res_q   <= '0;
      prio_b  <= PRIO_INIT;
      a_cnt   <= '0;
      b_cnt   <= '0;
    end else begin
      if (grant) begin
        valid_q <= 1'b1;
        res_q   <= '{exp:   bus.i_rnd_exp,
                     mant:  bus.i_rnd_mant,
                     ov_fl: bus.i_rnd_ov_fl,
                     un_fl: bus.i_rnd_un_fl,
                     src:   grant_b};
      end else if (bus.i_ready) begin
        valid_q <= 1'b0;  // drained, data left as-is
      end

      // Pointer only moves after a real contention, to the loser.
      if (bus.i_a_valid && bus.i_b_valid && grant) begin
        prio_b <= grant_a;
      end

      if (grant_a && (a_cnt != '1)) a_cnt <= a_cnt + 1'b1;
      if (grant_b && (b_cnt != '1)) b_cnt <= b_cnt + 1'b1;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_exp   = res_q.exp;
  assign bus.o_mant  = res_q.mant;
  assign bus.o_ov_fl = res_q.ov_fl;
  assign bus.o_un_fl = res_q.un_fl;
  assign bus.o_src   = res_q.src;
  assign bus.o_a_cnt = a_cnt;
  assign bus.o_b_cnt = b_cnt;

endmodule

// File: tb/tb_fpu_round_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_round_arbiter
// Directed bench for fpu_round_arbiter. dut0 (PRIO_INIT=0, CNT_W=16) runs a
// cycle-by-cycle vector table plus a mid-stream reset; dut1 (PRIO_INIT=1,
// CNT_W=4) covers initial priority and counter saturation. A small
// round-to-nearest-even model stands in for the shared rounding unit.
// -----------------------------------------------------------------------------
module tb_fpu_round_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fpu_round_arbiter_if #(.CNT_W(16)) bus0 ();
  fpu_round_arbiter_if #(.CNT_W(4))  bus1 ();

  fpu_round_arbiter #(.PRIO_INIT(1'b0), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  fpu_round_arbiter #(.PRIO_INIT(1'b1), .CNT_W(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  // Rounding-unit stand-in: RNE on [26:4] with G/R/S, carry bumps exponent.
  typedef struct packed {
    logic [7:0]  exp;
    logic [22:0] mant;
    logic        ov;
    logic        un;
  } rnd_t;

  function automatic rnd_t rnd_model(logic [7:0] e, logic [27:0] m, logic ov, logic un);
    rnd_t  r;
    logic  up;
    logic [23:0] sum;
    up     = m[3] & (m[2] | m[1] | m[0] | m[4]);
    sum    = {1'b0, m[26:4]} + {23'd0, up};
    r.exp  = e + {7'd0, sum[23]} + {7'd0, m[27]};
    r.mant = sum[22:0];
    r.ov   = ov | (r.exp == 8'hFF);
    r.un   = un;
    return r;
  endfunction

  rnd_t r0, r1;
  always_comb begin
    r0 = rnd_model(bus0.o_rnd_exp, bus0.o_rnd_mant, bus0.o_rnd_ov_fl, bus0.o_rnd_un_fl);
    r1 = rnd_model(bus1.o_rnd_exp, bus1.o_rnd_mant, bus1.o_rnd_ov_fl, bus1.o_rnd_un_fl);
  end
  assign bus0.i_rnd_exp   = r0.exp;
  assign bus0.i_rnd_mant  = r0.mant;
  assign bus0.i_rnd_ov_fl = r0.ov;
  assign bus0.i_rnd_un_fl = r0.un;
  assign bus1.i_rnd_exp   = r1.exp;
  assign bus1.i_rnd_mant  = r1.mant;
  assign bus1.i_rnd_ov_fl = r1.ov;
  assign bus1.i_rnd_un_fl = r1.un;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        av, bv;
    logic [7:0]  ae;
    logic [27:0] am;
    logic        aun;
    logic [7:0]  be;
    logic [27:0] bm;
    logic        rdy;
    logic        x_ar, x_br;
    logic [7:0]  x_rnd_exp;
    logic        x_valid;
    logic [7:0]  x_exp;
    logic [22:0] x_mant;
    logic        x_ov, x_un, x_src;
    logic [15:0] x_acnt, x_bcnt;
  } vec_t;

  function automatic vec_t mk(
      logic av, logic bv, logic [7:0] ae, logic [27:0] am, logic aun,
      logic [7:0] be, logic [27:0] bm, logic rdy,
      logic xar, logic xbr, logic [7:0] xre,
      logic xv, logic [7:0] xe, logic [22:0] xm, logic xov, logic xun,
      logic xsrc, logic [15:0] xac, logic [15:0] xbc);
    vec_t v;
    v.av = av; v.bv = bv; v.ae = ae; v.am = am; v.aun = aun;
    v.be = be; v.bm = bm; v.rdy = rdy;
    v.x_ar = xar; v.x_br = xbr; v.x_rnd_exp = xre;
    v.x_valid = xv; v.x_exp = xe; v.x_mant = xm; v.x_ov = xov; v.x_un = xun;
    v.x_src = xsrc; v.x_acnt = xac; v.x_bcnt = xbc;
    return v;
  endfunction

  task automatic drive0(input logic av, input logic bv, input logic [7:0] ae,
                        input logic [27:0] am, input logic aun, input logic [7:0] be,
                        input logic [27:0] bm, input logic rdy);
    bus0.i_a_valid = av; bus0.i_a_exp = ae; bus0.i_a_mant = am;
    bus0.i_a_ov_fl = 1'b0; bus0.i_a_un_fl = aun;
    bus0.i_b_valid = bv; bus0.i_b_exp = be; bus0.i_b_mant = bm;
    bus0.i_b_ov_fl = 1'b0; bus0.i_b_un_fl = 1'b0;
    bus0.i_ready   = rdy;
  endtask

  task automatic drive1(input logic av, input logic bv, input logic rdy);
    bus1.i_a_valid = av; bus1.i_a_exp = 8'h11; bus1.i_a_mant = 28'h0000018;
    bus1.i_a_ov_fl = 1'b0; bus1.i_a_un_fl = 1'b0;
    bus1.i_b_valid = bv; bus1.i_b_exp = 8'h22; bus1.i_b_mant = 28'h0000014;
    bus1.i_b_ov_fl = 1'b0; bus1.i_b_un_fl = 1'b0;
    bus1.i_ready   = rdy;
  endtask

  vec_t vecs[14];

  initial begin
    //               av bv ae     am            aun be     bm            rdy ar br rnd    v  exp    mant  ov un src acnt bcnt
    vecs[0]  = mk(1, 0, 8'h10, 28'h0000018, 0, 8'h00, 28'h0000000, 1,  1, 0, 8'h10, 1, 8'h10, 23'h2, 0, 0, 0, 1, 0); // A alone
    vecs[1]  = mk(1, 1, 8'h20, 28'h000003C, 0, 8'h30, 28'h0000014, 1,  1, 0, 8'h20, 1, 8'h20, 23'h4, 0, 0, 0, 2, 0); // contention: A
    vecs[2]  = mk(1, 1, 8'h21, 28'h0000008, 0, 8'h30, 28'h0000014, 1,  0, 1, 8'h30, 1, 8'h30, 23'h1, 0, 0, 1, 2, 1); // B
    vecs[3]  = mk(1, 1, 8'h21, 28'h0000008, 0, 8'h31, 28'h000003C, 1,  1, 0, 8'h21, 1, 8'h21, 23'h0, 0, 0, 0, 3, 1); // A (tie to even)
    vecs[4]  = mk(1, 1, 8'h22, 28'h0000018, 0, 8'h31, 28'h000003C, 1,  0, 1, 8'h31, 1, 8'h31, 23'h4, 0, 0, 1, 3, 2); // B
    vecs[5]  = mk(1, 1, 8'h22, 28'h0000018, 0, 8'h32, 28'h0000014, 0,  0, 0, 8'h00, 1, 8'h31, 23'h4, 0, 0, 1, 3, 2); // backpressure
    vecs[6]  = mk(1, 1, 8'h22, 28'h0000018, 0, 8'h32, 28'h0000014, 0,  0, 0, 8'h00, 1, 8'h31, 23'h4, 0, 0, 1, 3, 2);
    vecs[7]  = mk(1, 1, 8'h22, 28'h0000018, 0, 8'h32, 28'h0000014, 0,  0, 0, 8'h00, 1, 8'h31, 23'h4, 0, 0, 1, 3, 2);
    vecs[8]  = mk(1, 1, 8'h22, 28'h0000018, 0, 8'h32, 28'h0000014, 1,  1, 0, 8'h22, 1, 8'h22, 23'h2, 0, 0, 0, 4, 2); // drain + grant
    vecs[9]  = mk(0, 1, 8'h00, 28'h0000000, 0, 8'hFE, 28'h7FFFFF8, 1,  0, 1, 8'hFE, 1, 8'hFF, 23'h0, 1, 0, 1, 4, 3); // carry/overflow
    vecs[10] = mk(0, 0, 8'h00, 28'h0000000, 0, 8'h00, 28'h0000000, 1,  0, 0, 8'h00, 0, 8'hFF, 23'h0, 1, 0, 1, 4, 3); // drain, data held
    vecs[11] = mk(0, 0, 8'h00, 28'h0000000, 0, 8'h00, 28'h0000000, 0,  0, 0, 8'h00, 0, 8'hFF, 23'h0, 1, 0, 1, 4, 3); // idle
    vecs[12] = mk(1, 0, 8'h40, 28'h0000014, 1, 8'h00, 28'h0000000, 1,  1, 0, 8'h40, 1, 8'h40, 23'h1, 0, 1, 0, 5, 3); // A, underflow flag
    vecs[13] = mk(1, 1, 8'h41, 28'h000003C, 0, 8'h50, 28'h0000008, 1,  0, 1, 8'h50, 1, 8'h50, 23'h0, 0, 0, 1, 5, 4); // pointer still at B

    rst_n = 1'b0;
    drive0(0, 0, 8'h00, 28'h0, 0, 8'h00, 28'h0, 0);
    drive1(0, 0, 0);
    #2;
    check("rst_valid",  {31'd0, bus0.o_valid}, 32'd0);
    check("rst_exp",    {24'd0, bus0.o_exp},   32'd0);
    check("rst_mant",   {9'd0,  bus0.o_mant},  32'd0);
    check("rst_flags",  {29'd0, bus0.o_ov_fl, bus0.o_un_fl, bus0.o_src}, 32'd0);
    check("rst_cnts",   {bus0.o_a_cnt, bus0.o_b_cnt}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      drive0(vecs[i].av, vecs[i].bv, vecs[i].ae, vecs[i].am, vecs[i].aun,
             vecs[i].be, vecs[i].bm, vecs[i].rdy);
      #1;
      check($sformatf("v%0d a_ready", i),  {31'd0, bus0.o_a_ready}, {31'd0, vecs[i].x_ar});
      check($sformatf("v%0d b_ready", i),  {31'd0, bus0.o_b_ready}, {31'd0, vecs[i].x_br});
      check($sformatf("v%0d rnd_exp", i),  {24'd0, bus0.o_rnd_exp}, {24'd0, vecs[i].x_rnd_exp});
      @(posedge clk); #1;
      check($sformatf("v%0d valid", i),    {31'd0, bus0.o_valid},   {31'd0, vecs[i].x_valid});
      check($sformatf("v%0d exp", i),      {24'd0, bus0.o_exp},     {24'd0, vecs[i].x_exp});
      check($sformatf("v%0d mant", i),     {9'd0,  bus0.o_mant},    {9'd0,  vecs[i].x_mant});
      check($sformatf("v%0d ov", i),       {31'd0, bus0.o_ov_fl},   {31'd0, vecs[i].x_ov});
      check($sformatf("v%0d un", i),       {31'd0, bus0.o_un_fl},   {31'd0, vecs[i].x_un});
      check($sformatf("v%0d src", i),      {31'd0, bus0.o_src},     {31'd0, vecs[i].x_src});
      check($sformatf("v%0d a_cnt", i),    {16'd0, bus0.o_a_cnt},   {16'd0, vecs[i].x_acnt});
      check($sformatf("v%0d b_cnt", i),    {16'd0, bus0.o_b_cnt},   {16'd0, vecs[i].x_bcnt});
    end

    // Mid-stream reset: first move the pointer to B, then show reset puts it
    // back to A while clearing valid, readies and counters asynchronously.
    drive0(1, 1, 8'h60, 28'h0000018, 0, 8'h70, 28'h0000014, 1);
    #1 check("pre_rst a_ready", {31'd0, bus0.o_a_ready}, 32'd1);
    @(posedge clk); #1;
    check("pre_rst valid", {31'd0, bus0.o_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid valid",   {31'd0, bus0.o_valid},   32'd0);
    check("rst_mid a_ready", {31'd0, bus0.o_a_ready}, 32'd0);
    check("rst_mid b_ready", {31'd0, bus0.o_b_ready}, 32'd0);
    check("rst_mid a_cnt",   {16'd0, bus0.o_a_cnt},   32'd0);
    check("rst_mid b_cnt",   {16'd0, bus0.o_b_cnt},   32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst a_ready", {31'd0, bus0.o_a_ready}, 32'd1);
    check("post_rst b_ready", {31'd0, bus0.o_b_ready}, 32'd0);
    @(posedge clk); #1;
    check("post_rst src",   {31'd0, bus0.o_src},   32'd0);
    check("post_rst exp",   {24'd0, bus0.o_exp},   32'h60);
    check("post_rst a_cnt", {16'd0, bus0.o_a_cnt}, 32'd1);
    drive0(0, 0, 8'h00, 28'h0, 0, 8'h00, 28'h0, 1);

    // dut1: B holds priority after reset, then A saturates its 4-bit counter.
    drive1(1, 1, 1);
    #1;
    check("d1 init b_ready", {31'd0, bus1.o_b_ready}, 32'd1);
    check("d1 init a_ready", {31'd0, bus1.o_a_ready}, 32'd0);
    @(posedge clk); #1;
    check("d1 src", {31'd0, bus1.o_src}, 32'd1);
    check("d1 exp", {24'd0, bus1.o_exp}, 32'h22);
    drive1(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 14) check("d1 a_cnt at 15", {28'd0, bus1.o_a_cnt}, 32'd15);
    end
    check("d1 a_cnt sat", {28'd0, bus1.o_a_cnt}, 32'd15);
    check("d1 b_cnt",     {28'd0, bus1.o_b_cnt}, 32'd1);
    drive1(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
